uart_rx_frame: RTL

Parametrised UART receiver: next generation of the fixed 8-bit RX path. Oversamples the serial line, validates the start bit and recovers a DATA_W-bit word LSB first. Optional even/odd parity is checked, the stop bit is checked, and each frame ends with a one-cycle RX_DONE strobe. The block sits between the serial pad synchroniser and the parallel consumer, in place of the fixed-format receiver.

---
 rtl/uart_rx_frame.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver, DATA_W data bits LSB first,
// optional even/odd parity, one stop bit, one-cycle RX_DONE per frame.
// Build option: define UART_RX_MAJORITY_EN to decide each bit by 2-of-3
// majority of the samples at ticks D-2, D-1, D (D = PRESCALE/2+1); without
// it the bit is the single sample at tick PRESCALE/2. Decision latency is
// the same in both builds.
module uart_rx_frame #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PRESCALE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic [DATA_W-1:0] P_DATA_OUT,
  output logic              RX_DONE,
  output logic              PAR_ERR,
  output logic              STP_ERR,
  output logic              Busy
);

  localparam int unsigned TK_W = $clog2(PRESCALE);
  localparam int unsigned BC_W = $clog2(DATA_W);
  localparam int unsigned DEC  = PRESCALE / 2 + 1;

  localparam logic [TK_W-1:0] TK_ONE  = TK_W'(1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(PRESCALE - 1);
  localparam logic [TK_W-1:0] TK_DEC  = TK_W'(DEC);
  localparam logic [TK_W-1:0] TK_MID  = TK_W'(PRESCALE / 2);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t            r_state;
  logic [TK_W-1:0]   r_tk;
  logic [BC_W-1:0]   r_bc;
  logic [DATA_W-1:0] r_shift;
  logic              r_pe;
  logic              r_pt;
  logic              r_par_res;
  logic              r_s1;
  logic [DATA_W-1:0] r_data;
  logic              r_done;
  logic              r_par_err;
  logic              r_stp_err;
  logic              r_busy;
  logic              w_bit;
  logic              w_wrap;
  logic              w_dec;

  assign w_wrap = (r_tk == TK_LAST);
  assign w_dec  = (r_tk == TK_DEC);

`ifdef UART_RX_MAJORITY_EN
  logic r_s0;

  // Capture the earliest of the three majority samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s0 <= 1'b0;
    end else if (r_state != ST_IDLE && r_tk == TK_W'(DEC - 2)) begin
      r_s0 <= RX_IN;
    end
  end

  assign w_bit = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
`else
  assign w_bit = r_s1;
`endif

  // Frame FSM: tick/bit counters, shift register, registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_tk      <= '0;
      r_bc      <= '0;
      r_shift   <= '0;
      r_pe      <= 1'b0;
      r_pt      <= 1'b0;
      r_par_res <= 1'b0;
      r_s1      <= 1'b0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != ST_IDLE && r_tk == TK_MID) begin
        r_s1 <= RX_IN;
      end
      if (r_state != ST_IDLE) begin
        r_tk <= w_wrap ? '0 : r_tk + TK_ONE;
      end
      case (r_state)
        ST_IDLE: begin
          if (!RX_IN) begin
            r_state   <= ST_START;
            r_tk      <= TK_ONE;
            r_bc      <= '0;
            r_pe      <= PAR_EN;
            r_pt      <= PAR_TYP;
            r_par_res <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        ST_START: begin
          if (w_dec && w_bit) begin
            r_state <= ST_IDLE;
            r_tk    <= '0;
            r_busy  <= 1'b0;
          end else if (w_wrap) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_dec) begin
            r_shift <= {w_bit, r_shift[DATA_W-1:1]};
          end
          if (w_wrap) begin
            if (r_bc == BC_LAST) begin
              r_bc    <= '0;
              r_state <= r_pe ? ST_PARITY : ST_STOP;
            end else begin
              r_bc <= r_bc + BC_ONE;
            end
          end
        end
        ST_PARITY: begin
          if (w_dec) begin
            r_par_res <= ((^r_shift) ^ w_bit) != r_pt;
          end
          if (w_wrap) begin
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_dec) begin
            r_data    <= r_shift;
            r_stp_err <= ~w_bit;
            r_par_err <= r_pe & r_par_res;
            r_done    <= 1'b1;
            r_state   <= ST_IDLE;
            r_tk      <= '0;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tk    <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign P_DATA_OUT = r_data;
  assign RX_DONE    = r_done;
  assign PAR_ERR    = r_par_err;
  assign STP_ERR    = r_stp_err;
  assign Busy       = r_busy;

endmodule
